axi_lsu_rd_arbiter: RTL
=======================

// Module: axi_lsu_rd_arbiter
// PURPOSE
//  Two-requester AXI read-channel arbiter in front of the LSU/DMA bridge master read port.
//  Requester 0 is the LSU; requester 1 is the testbench DMA injector.
//  Shares one AR/R path: round-robin AR grant, ID tagging, R routing, per-requester outstanding limit.
//  Downstream port connects to the bridge m_ar*/m_r* inputs; S_ID_WIDTH matches bridge M_ID_WIDTH.
// PARAMETERS
//  ID_WIDTH        8  requester ARID/RID width
//  S_ID_WIDTH      9  downstream ID width; fixed = ID_WIDTH+1 (MSB = requester index)
//  MAX_OUTSTANDING 4  max read bursts in flight per requester (1..15)
// PORTS
//  clk          in   1            clock
//  reset_l      in   1            async active-low reset
//  m_arvalid    in   2            AR valid, bit i = requester i
//  m_arid       in   2*ID_WIDTH   {id1,id0}
//  m_araddr     in   64           {addr1,addr0}
//  m_arready    out  2            AR ready per requester
//  m_rvalid     out  2            R valid per requester
//  m_rready     in   2            R ready per requester
//  m_rdata      out  128          R data, broadcast to both requesters
//  m_rid        out  ID_WIDTH     R id, broadcast
//  m_rresp      out  2            R resp, broadcast
//  m_rlast      out  1            R last, broadcast
//  s_arvalid    out  1            downstream AR valid
//  s_arid       out  S_ID_WIDTH   {grant_idx, granted arid}
//  s_araddr     out  32           granted address
//  s_arready    in   1            downstream AR ready
//  s_rvalid     in   1            downstream R valid
//  s_rready     out  1            downstream R ready
//  s_rdata      in   128          downstream R data
//  s_rid        in   S_ID_WIDTH   downstream R id
//  s_rresp      in   2            downstream R resp
//  s_rlast      in   1            downstream R last
// BEHAVIOUR
//  Reset: FSM IDLE, rr_ptr=0 (requester 0 preferred), both outstanding counters 0.
//  Reset also forces s_arvalid=0 and m_arready=0; reset mid-burst drops all state, no flush.
//  Eligible[i] = m_arvalid[i] & (cnt[i] != MAX_OUTSTANDING).
//  FSM states: IDLE, GNT0, GNT1.
//  - IDLE: no output asserted.
//    If both requesters eligible, go to GNT(rr_ptr); if one eligible, go to GNT of that one.
//  - GNTi: s_arvalid = m_arvalid[i]; s_araddr/s_arid muxed from requester i; m_arready[i] = s_arready.
//    The other requester's m_arready = 0.
//  - GNTi on s_arvalid & s_arready: go to IDLE, set rr_ptr = ~i, cnt[i]++.
//  Arbitration latency 1 cycle; AR throughput 1 address per 2 cycles.
//  Grant is held until handshake. A requester dropping arvalid while granted violates protocol;
//  the grant is kept and s_arvalid follows the requester's valid.
//  R routing: sel = s_rid[S_ID_WIDTH-1].
//  m_rvalid[sel] = s_rvalid; the other bit is 0. s_rready = m_rready[sel].
//  m_rid = s_rid[ID_WIDTH-1:0]. R path is purely combinational, 0 cycles.
//  cnt[sel]-- on s_rvalid & s_rready & s_rlast.
//  Increment and decrement of the same counter in one cycle: count unchanged.
//  cnt never wraps. At MAX_OUTSTANDING the requester is ineligible until a last beat returns.
//  Decrement at 0 is a protocol error: the counter holds 0.
// CONFIGURATION
//  RV_LSU_RD_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are eligible;
//  rr_ptr is not updated.
//  Undefined: round-robin as described above.
// TESTING
//  1. Single request: m_arvalid=01, addr0=0x1000, id0=0x5, s_arready=1.
//     -> s_arvalid next cycle with s_arid=0x005; m_arready[0] high in that cycle; cnt0=1.
//  2. Contention: m_arvalid=11 held for 4 grants.
//     -> grant order 0,1,0,1; s_arid MSB alternates.
//     With FIXED_PRIO_EN -> order 0,0,0,0.
//  3. R routing: s_rvalid=1, s_rid=0x1A3, s_rlast=1, m_rready=10.
//     -> m_rvalid=10, m_rid=0xA3, s_rready=1, cnt1 decremented.
//  4. Limit: 4 reads from requester 0 with no R returned.
//     -> 5th request not granted; requester 1 still granted.
//     After one rlast to requester 0 -> 5th request is granted.
//  5. Simultaneous: AR handshake for requester 0 in the same cycle as rlast to requester 0
//     -> cnt0 unchanged.
//     Assert reset_l=0 mid-grant -> s_arvalid=0 immediately; cnt=0.

Source files
------------

// File: rtl/axi_lsu_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin AR grant, requester-tagged IDs, R routing, outstanding limit.
// Define RV_LSU_RD_ARB_FIXED_PRIO_EN to make requester 0 always win a tie (no round-robin pointer).

module axi_lsu_rd_arb_cnt #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = 4
) (
  input  logic clk,
  input  logic reset_l,
  input  logic inc,
  input  logic dec,
  output logic full
);
  logic [CW-1:0] cnt;

  // Simultaneous inc/dec cancels; never wraps at either end.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)                           cnt <= '0;
    else if (inc && !dec && !full)          cnt <= cnt + 1'b1;
    else if (dec && !inc && (cnt != '0))    cnt <= cnt - 1'b1;
  end

  assign full = (cnt == CW'(MAX_OUTSTANDING));
endmodule

module axi_lsu_rd_arbiter #(
  parameter int ID_WIDTH        = 8,
  parameter int S_ID_WIDTH      = 9,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic [1:0]              m_arvalid,
  input  logic [2*ID_WIDTH-1:0]   m_arid,
  input  logic [63:0]             m_araddr,
  output logic [1:0]              m_arready,
  output logic [1:0]              m_rvalid,
  input  logic [1:0]              m_rready,
  output logic [127:0]            m_rdata,
  output logic [ID_WIDTH-1:0]     m_rid,
  output logic [1:0]              m_rresp,
  output logic                    m_rlast,
  output logic                    s_arvalid,
  output logic [S_ID_WIDTH-1:0]   s_arid,
  output logic [31:0]             s_araddr,
  input  logic                    s_arready,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  input  logic [127:0]            s_rdata,
  input  logic [S_ID_WIDTH-1:0]   s_rid,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast
);
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t                   state, state_n;
  logic [1:0][ID_WIDTH-1:0] ids;
  logic [1:0][31:0]         addrs;
  logic [1:0]               elig, full, inc, dec;
  logic                     granted, gnt_idx, ar_hs, r_sel;

  assign ids   = m_arid;
  assign addrs = m_araddr;
  assign elig  = m_arvalid & ~full;

  assign granted = (state != IDLE);
  assign gnt_idx = (state == GNT1);
  assign ar_hs   = s_arvalid & s_arready;

  // AR mux: everything quiet in IDLE, so async reset drops s_arvalid immediately.
  always_comb begin
    s_arvalid = 1'b0;
    s_arid    = '0;
    s_araddr  = '0;
    m_arready = '0;
    if (granted) begin
      s_arvalid          = m_arvalid[gnt_idx];
      s_arid             = {gnt_idx, ids[gnt_idx]};
      s_araddr           = addrs[gnt_idx];
      m_arready[gnt_idx] = s_arready;
    end
  end

`ifdef RV_LSU_RD_ARB_FIXED_PRIO_EN
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (elig[0])      state_n = GNT0;
                  else if (elig[1]) state_n = GNT1;
      GNT0, GNT1: if (ar_hs)        state_n = IDLE;
      default:                      state_n = IDLE;
    endcase
  end
`else
  logic rr_ptr, rr_ptr_n;

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    case (state)
      IDLE: begin
        if (&elig)        state_n = rr_ptr ? GNT1 : GNT0;
        else if (elig[0]) state_n = GNT0;
        else if (elig[1]) state_n = GNT1;
      end
      GNT0, GNT1: begin
        if (ar_hs) begin
          state_n  = IDLE;
          rr_ptr_n = ~gnt_idx;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) rr_ptr <= 1'b0;
    else          rr_ptr <= rr_ptr_n;
  end
`endif

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_n;
  end

  // R path: requester index lives in the downstream ID MSB.
  assign r_sel    = s_rid[S_ID_WIDTH-1];
  assign m_rvalid = r_sel ? {s_rvalid, 1'b0} : {1'b0, s_rvalid};
  assign s_rready = m_rready[r_sel];
  assign m_rid    = s_rid[ID_WIDTH-1:0];
  assign m_rdata  = s_rdata;
  assign m_rresp  = s_rresp;
  assign m_rlast  = s_rlast;

  always_comb begin
    inc = '0;
    dec = '0;
    if (ar_hs)                          inc[gnt_idx] = 1'b1;
    if (s_rvalid && s_rready && s_rlast) dec[r_sel]   = 1'b1;
  end

  for (genvar g = 0; g < 2; g++) begin : g_req
    axi_lsu_rd_arb_cnt #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING),
      .CW             (CW)
    ) u_cnt (
      .clk    (clk),
      .reset_l(reset_l),
      .inc    (inc[g]),
      .dec    (dec[g]),
      .full   (full[g])
    );
  end
endmodule
